mul_result_serializer: RTL and testbench

- Downstream stage of the radix-8 Booth multiplier.
- Watches the multiplier's 67-bit sign-extended product and its level-type done flag (suff).
- Captures each new result once and derives status flags: neg, zero, 64-bit overflow.
- Streams the 64-bit result to a 32-bit writeback bus as two words (low first, then high) under a valid/ready handshake.

---
 rtl/mul_result_serializer_pkg.sv | 30 +++
 rtl/mul_flag_gen.sv | 17 +
 rtl/mul_result_serializer.sv | 130 +++++++++++++
 tb/tb_mul_result_serializer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_result_serializer_pkg.sv
// Shared constants and state encoding for the multiplier writeback path.
// Product widths and the one-hot FSM encoding used by the control units.
package mul_result_serializer_pkg;

    localparam int unsigned PROD_W = 67;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned RES_W  = 2 * WORD_W;

    localparam logic [2:0] ST_IDLE    = 3'b001;
    localparam logic [2:0] ST_SEND_LO = 3'b010;
    localparam logic [2:0] ST_SEND_HI = 3'b100;

    typedef enum logic [2:0] {
        StIdle   = ST_IDLE,
        StSendLo = ST_SEND_LO,
        StSendHi = ST_SEND_HI
    } ser_state_e;

    typedef struct packed {
        logic neg;
        logic zero;
        logic ovf;
    } res_flags_t;

    // True when every bit of the vector is equal, i.e. pure sign extension.
    function automatic logic all_same(input logic [PROD_W-RES_W:0] v);
        return (v == '0) || (v == '1);
    endfunction

endpackage

// File: rtl/mul_flag_gen.sv
// Combinational status flags for a sign-extended product.
// Upper bits beyond the 64-bit result only feed the overflow check.
module mul_flag_gen
    import mul_result_serializer_pkg::*;
(
    input  logic [PROD_W-1:0] product_i,
    output res_flags_t        flags_o
);

    always_comb begin
        flags_o      = '0;
        flags_o.neg  = product_i[PROD_W-1];
        flags_o.zero = (product_i[RES_W-1:0] == '0);
        flags_o.ovf  = ~all_same(product_i[PROD_W-1:RES_W-1]);
    end

endmodule

// File: rtl/mul_result_serializer.sv
// Captures each new multiplier result and streams it as two 32-bit words,
// low word first, under a valid/ready handshake with registered outputs.
module mul_result_serializer
    import mul_result_serializer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [PROD_W-1:0] product_in,
    input  logic              suff_in,
    output logic [WORD_W-1:0] data_out,
    output logic              word_hi,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              neg,
    output logic              zero,
    output logic              ovf,
    output logic              busy,
    output logic              lost
);

    ser_state_e        state_q, state_d;
    logic [RES_W-1:0]  cap_q, cap_d;
    res_flags_t        flags_q, flags_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              word_hi_q, word_hi_d;
    logic              suff_q, suff_d;
    logic              lost_q, lost_d;

    res_flags_t in_flags;
    logic       new_res;
    logic       accept;

    mul_flag_gen u_flag_gen (
        .product_i (product_in),
        .flags_o   (in_flags)
    );

    assign new_res = suff_in & ~suff_q;
    assign accept  = valid_q & ready_in;

    always_comb begin
        state_d   = state_q;
        cap_d     = cap_q;
        flags_d   = flags_q;
        data_d    = data_q;
        valid_d   = valid_q;
        word_hi_d = word_hi_q;
        suff_d    = suff_in;
        lost_d    = lost_q;

        unique case (state_q)
            StIdle: begin
                if (new_res) begin
                    state_d   = StSendLo;
                    cap_d     = product_in[RES_W-1:0];
                    flags_d   = in_flags;
                    data_d    = product_in[WORD_W-1:0];
                    valid_d   = 1'b1;
                    word_hi_d = 1'b0;
                end
            end
            StSendLo: begin
                if (new_res) begin
                    lost_d = 1'b1;
                end
                if (accept) begin
                    state_d   = StSendHi;
                    data_d    = cap_q[RES_W-1:WORD_W];
                    word_hi_d = 1'b1;
                end
            end
            StSendHi: begin
                if (accept) begin
                    if (new_res) begin
                        // Back-to-back result: start the next transfer without an idle gap.
                        state_d   = StSendLo;
                        cap_d     = product_in[RES_W-1:0];
                        flags_d   = in_flags;
                        data_d    = product_in[WORD_W-1:0];
                        word_hi_d = 1'b0;
                    end else begin
                        state_d   = StIdle;
                        valid_d   = 1'b0;
                    end
                end else if (new_res) begin
                    lost_d = 1'b1;
                end
            end
            default: begin
                state_d   = StIdle;
                valid_d   = 1'b0;
                word_hi_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cap_q     <= '0;
            flags_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            word_hi_q <= 1'b0;
            // A level already high at reset release must not count as a new result.
            suff_q    <= 1'b1;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cap_q     <= cap_d;
            flags_q   <= flags_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            word_hi_q <= word_hi_d;
            suff_q    <= suff_d;
            lost_q    <= lost_d;
        end
    end

    assign data_out  = data_q;
    assign word_hi   = word_hi_q;
    assign valid_out = valid_q;
    assign neg       = flags_q.neg;
    assign zero      = flags_q.zero;
    assign ovf       = flags_q.ovf;
    assign busy      = (state_q != StIdle);
    assign lost      = lost_q;

endmodule

// File: tb/tb_mul_result_serializer.sv
// Directed self-checking bench for mul_result_serializer.
module tb_mul_result_serializer;

    logic        clk;
    logic        rst;
    logic [66:0] product_in;
    logic        suff_in;
    logic [31:0] data_out;
    logic        word_hi;
    logic        valid_out;
    logic        ready_in;
    logic        neg;
    logic        zero;
    logic        ovf;
    logic        busy;
    logic        lost;

    int checks;
    int errors;

    mul_result_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .product_in (product_in),
        .suff_in    (suff_in),
        .data_out   (data_out),
        .word_hi    (word_hi),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .neg        (neg),
        .zero       (zero),
        .ovf        (ovf),
        .busy       (busy),
        .lost       (lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then stable for sampling and inputs may change.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        suff_in    = 1'b0;
        ready_in   = 1'b0;
        product_in = '0;
        tick();
        tick();
        checks++;
        if ({valid_out, word_hi, data_out} !== 34'h0) begin
            $display("FAIL reset_out got v=%b h=%b d=%h want 0 0 00000000",
                     valid_out, word_hi, data_out);
            errors++;
        end
        checks++;
        if ({neg, zero, ovf, busy, lost} !== 5'b00000) begin
            $display("FAIL reset_flags got %b want 00000", {neg, zero, ovf, busy, lost});
            errors++;
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic send_one(input string name, input logic [66:0] p,
                            input logic [31:0] lo, input logic [31:0] hi,
                            input logic [2:0] exp_flags);
        ready_in   = 1'b1;
        product_in = p;
        suff_in    = 1'b1;
        tick();
        suff_in = 1'b0;
        checks++;
        if ({valid_out, word_hi, data_out} !== {2'b10, lo}) begin
            $display("FAIL %s_lo got v=%b h=%b d=%h want 1 0 %h",
                     name, valid_out, word_hi, data_out, lo);
            errors++;
        end
        checks++;
        if ({neg, zero, ovf} !== exp_flags) begin
            $display("FAIL %s_flags got %b want %b", name, {neg, zero, ovf}, exp_flags);
            errors++;
        end
        tick();
        checks++;
        if ({valid_out, word_hi, data_out} !== {2'b11, hi}) begin
            $display("FAIL %s_hi got v=%b h=%b d=%h want 1 1 %h",
                     name, valid_out, word_hi, data_out, hi);
            errors++;
        end
        tick();
        checks++;
        if ({valid_out, busy, neg, zero, ovf} !== {2'b00, exp_flags}) begin
            $display("FAIL %s_idle got v=%b busy=%b flags=%b want 0 0 %b",
                     name, valid_out, busy, {neg, zero, ovf}, exp_flags);
            errors++;
        end
        tick();
    endtask

    task automatic test_basic();
        send_one("mul172", 67'h0_0000_0000_0000_7390, 32'h0000_7390, 32'h0000_0000, 3'b000);
        send_one("minus1", {67{1'b1}}, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b100);
        send_one("ovf", 67'h4_0000_0000_0000_0000, 32'h0, 32'h0, 3'b111);
        send_one("posovf", 67'h0_8000_0000_0000_0001, 32'h0000_0001, 32'h8000_0000, 3'b001);
    endtask

    task automatic test_backpressure();
        int held_bad;
        ready_in   = 1'b0;
        product_in = 67'h0_1234_5678_9ABC_DEF0;
        suff_in    = 1'b1;
        tick();
        held_bad = 0;
        for (int i = 0; i < 5; i++) begin
            if ({valid_out, word_hi, data_out} !== {2'b10, 32'h9ABC_DEF0}) held_bad++;
            tick();
        end
        checks++;
        if (held_bad != 0) begin
            $display("FAIL bp_hold got %0d unstable cycles want 0", held_bad);
            errors++;
        end
        ready_in = 1'b1;
        checks++;
        if ({valid_out, word_hi, data_out} !== {2'b10, 32'h9ABC_DEF0}) begin
            $display("FAIL bp_lo got v=%b h=%b d=%h want 1 0 9abcdef0",
                     valid_out, word_hi, data_out);
            errors++;
        end
        tick();
        checks++;
        if ({valid_out, word_hi, data_out} !== {2'b11, 32'h1234_5678}) begin
            $display("FAIL bp_hi got v=%b h=%b d=%h want 1 1 12345678",
                     valid_out, word_hi, data_out);
            errors++;
        end
        held_bad = 0;
        // suff_in has now been high 7 cycles; keep it high to 20 and expect no recapture.
        for (int i = 0; i < 13; i++) begin
            tick();
            if (valid_out !== 1'b0 || busy !== 1'b0) held_bad++;
        end
        checks++;
        if (held_bad != 0 || lost !== 1'b0) begin
            $display("FAIL bp_single got %0d busy cycles lost=%b want 0 0", held_bad, lost);
            errors++;
        end
        suff_in = 1'b0;
        tick();
    endtask

    task automatic test_collision();
        ready_in   = 1'b0;
        product_in = 67'h0_AAAA_0001_BBBB_0002;
        suff_in    = 1'b1;
        tick();
        suff_in    = 1'b0;
        product_in = 67'h7_FFFF_FFFF_0000_0000;
        tick();
        suff_in = 1'b1;
        tick();
        suff_in = 1'b0;
        checks++;
        if ({lost, valid_out, word_hi, data_out} !== {3'b110, 32'hBBBB_0002}) begin
            $display("FAIL coll_lo got lost=%b v=%b h=%b d=%h want 1 1 0 bbbb0002",
                     lost, valid_out, word_hi, data_out);
            errors++;
        end
        ready_in = 1'b1;
        tick();
        checks++;
        if ({valid_out, word_hi, data_out, neg} !== {2'b11, 32'hAAAA_0001, 1'b0}) begin
            $display("FAIL coll_hi got v=%b h=%b d=%h neg=%b want 1 1 aaaa0001 0",
                     valid_out, word_hi, data_out, neg);
            errors++;
        end
        product_in = 67'h0_CCCC_CCCC_DDDD_DDDD;
        suff_in    = 1'b1;
        tick();
        suff_in = 1'b0;
        checks++;
        if ({lost, valid_out, word_hi, data_out} !== {3'b110, 32'hDDDD_DDDD}) begin
            $display("FAIL b2b_lo got lost=%b v=%b h=%b d=%h want 1 1 0 dddddddd",
                     lost, valid_out, word_hi, data_out);
            errors++;
        end
        tick();
        checks++;
        if ({valid_out, word_hi, data_out} !== {2'b11, 32'hCCCC_CCCC}) begin
            $display("FAIL b2b_hi got v=%b h=%b d=%h want 1 1 cccccccc",
                     valid_out, word_hi, data_out);
            errors++;
        end
        tick();
        checks++;
        if ({valid_out, busy, lost} !== 3'b001) begin
            $display("FAIL b2b_idle got v=%b busy=%b lost=%b want 0 0 1", valid_out, busy, lost);
            errors++;
        end
    endtask

    task automatic test_reset_mid();
        ready_in   = 1'b1;
        product_in = 67'h4_0000_0000_0000_0005;
        suff_in    = 1'b1;
        tick();
        tick();
        checks++;
        if ({valid_out, word_hi} !== 2'b11) begin
            $display("FAIL rmid_pre got v=%b h=%b want 1 1", valid_out, word_hi);
            errors++;
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({valid_out, busy, lost, neg, zero, ovf, word_hi} !== 7'b0 || data_out !== 32'h0) begin
            $display("FAIL rmid_rst got v=%b busy=%b lost=%b flags=%b h=%b d=%h want all 0",
                     valid_out, busy, lost, {neg, zero, ovf}, word_hi, data_out);
            errors++;
        end
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({valid_out, busy} !== 2'b00) begin
            $display("FAIL rmid_held got v=%b busy=%b want 0 0", valid_out, busy);
            errors++;
        end
        suff_in = 1'b0;
        tick();
        product_in = 67'h0_0000_0001_0000_0002;
        suff_in    = 1'b1;
        tick();
        suff_in = 1'b0;
        checks++;
        if ({valid_out, word_hi, data_out} !== {2'b10, 32'h0000_0002}) begin
            $display("FAIL rmid_new got v=%b h=%b d=%h want 1 0 00000002",
                     valid_out, word_hi, data_out);
            errors++;
        end
        tick();
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
